// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the sequential multiplier and its bus interface.
package alu_pkg;
   localparam int MUL_W    = 16;
   localparam int MUL_ITER = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mul_state_t;
endpackage

// File: rtl/mul16_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential multiplier.
interface mul16_seq_if;
   import alu_pkg::*;

   logic                 start;
   logic [MUL_W-1:0]     a;
   logic [MUL_W-1:0]     b;
   logic [2*MUL_W-1:0]   product;
   logic                 busy;
   logic                 done;

   modport master (output start, a, b, input product, busy, done);
   modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/add16.sv
// 16-bit combinational ripple adder with carry in/out.
module add16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] sum,
   output logic        c_out
);
   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'h0, c_in};
endmodule

// File: rtl/mul16_seq.sv
// Unsigned 16x16->32 shift-add multiplier, one add16 pass per cycle, 16 iterations.
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | iterating; product shows partial values
module mul16_seq
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   mul16_seq_if.slave   bus
);
   mul_state_t        state_q, state_d;
   logic [MUL_W-1:0]  mcand_q;
   logic [MUL_W-1:0]  hi_q;
   logic [MUL_W-1:0]  lo_q;
   logic [3:0]        cnt_q;
   logic              done_q, done_d;
   logic              load, step;

   logic [MUL_W-1:0]  add_b;
   logic [MUL_W-1:0]  sum;
   logic              c_out;

   assign add_b = lo_q[0] ? mcand_q : '0;

   add16 u_add16 (
      .a     (hi_q),
      .b     (add_b),
      .c_in  (1'b0),
      .sum   (sum),
      .c_out (c_out)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == 4'(MUL_ITER - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Carry-out becomes the new MSB of hi; the bit shifted out of the sum enters lo.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else if (load) begin
         mcand_q <= bus.a;
         hi_q    <= '0;
         lo_q    <= bus.b;
         cnt_q   <= '0;
      end else if (step) begin
         hi_q    <= {c_out, sum[MUL_W-1:1]};
         lo_q    <= {sum[0], lo_q[MUL_W-1:1]};
         cnt_q   <= cnt_q + 4'd1;
      end
   end

   assign bus.product = {hi_q, lo_q};
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = done_q;
endmodule

// File: tb/tb_mul16_seq.sv
// Randomized self-checking bench for mul16_seq against a cycle-count/arithmetic model.
module tb_mul16_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   mul16_seq_if bus ();

   mul16_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: an accepted start schedules a*b to appear 16 edges later.
   int          rem = 0;
   logic [31:0] pend = '0;
   logic [31:0] m_prod = '0;
   logic        m_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem    = 0;
         m_done = 1'b0;
         m_prod = '0;
      end else begin
         m_done = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_done = 1'b1;
               m_prod = pend;
            end
         end else if (bus.start) begin
            rem  = 16;
            pend = 32'(bus.a) * 32'(bus.b);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(rem > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      if (rem == 0) chk("product", bus.product, m_prod);
   end

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) break;
         if (bus.busy) cyc++;
         @(negedge clk);
      end
      if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
   endtask

   task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] lit, input string nm);
      int cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.a = x; bus.b = y;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc);
      chk({nm, "_busy_cycles"}, 32'(cyc), 32'd16);
      chk({nm, "_product"}, bus.product, lit);
   endtask

   initial begin
      int cyc;
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_product", bus.product, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      run_op(16'd3, 16'd5, 32'h0000000F, "m3x5");
      @(negedge clk);
      chk("m3x5_done_pulse", 32'(bus.done), 32'd0);
      chk("m3x5_hold", bus.product, 32'h0000000F);
      run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mffff");
      run_op(16'h1234, 16'h5678, 32'h06260060, "m1234");
      run_op(16'h0000, 16'h1234, 32'h00000000, "mzero");

      // start re-pulsed mid-run must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'd11; bus.b = 16'd13;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.start = 1'b1; bus.a = 16'd7; bus.b = 16'd9;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc);
      chk("repulse_product", bus.product, 32'h0000008F);
      @(negedge clk);
      chk("repulse_done_once", 32'(bus.done), 32'd0);
      chk("repulse_idle", 32'(bus.busy), 32'd0);

      // start held through done: second op accepted in the done cycle
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'd3; bus.b = 16'd4;
      @(negedge clk);
      bus.a = 16'd2; bus.b = 16'd2;
      wait_done(cyc);
      chk("b2b_first", bus.product, 32'd12);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc);
      chk("b2b_cycles", 32'(cyc), 32'd16);
      chk("b2b_second", bus.product, 32'd4);

      // asynchronous reset mid-run
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_product", bus.product, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      run_op(16'd6, 16'd7, 32'd42, "m6x7");

      // randomized traffic, including start noise during runs
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         case ($urandom_range(0, 5))
            0: bus.a = 16'hFFFF;
            1: bus.b = 16'h0000;
            2: bus.b = 16'hFFFF;
            default: ;
         endcase
         @(negedge clk);
         bus.start = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (bus.done) break;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(negedge clk);
         end
         if (!bus.done) chk("rand_timeout", 32'(bus.done), 32'd1);
         bus.start = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (bus.busy) wait_done(cyc);
      end

      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
